// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: committed payload, status flags and acknowledge.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_out;
   logic                 data_ready;
   logic                 data_ack;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      output data_out,
      output data_ready,
      output parity_err,
      output frame_err,
      output overrun,
      input  data_ack
   );

   modport slave (
      input  data_out,
      input  data_ready,
      input  parity_err,
      input  frame_err,
      input  overrun,
      output data_ack
   );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver with configurable framing, a single-entry output
// buffer, overrun detection and break handling.
module uart_rx #(
   parameter int CLOCK_FREQ = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      bit_in,
   output logic      busy,
   uart_rx_if.master rx
);

   localparam int         TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int         DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int         SMP_W    = $clog2(OVERSAMPLE);
   localparam int         BIT_W    = 4;
   localparam logic [1:0] PAR_MODE = 2'(PARITY);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Mode 1 expects odd total ones, mode 2 even; any other mode never flags.
   function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                         input logic pbit,
                                         input logic [1:0] mode);
      logic sum;
      sum = ^{data, pbit};
      case (mode)
         2'd1:    return (sum != 1'b1);
         2'd2:    return (sum != 1'b0);
         default: return 1'b0;
      endcase
   endfunction

   logic                 sync1_r, sync2_r;
   logic                 line_s;
   logic [DIV_W-1:0]     div_cnt_r;
   logic                 tick_s;
   state_t               state_r, state_nxt;
   logic [SMP_W-1:0]     smp_cnt_r, smp_nxt;
   logic [BIT_W-1:0]     bit_cnt_r, bit_nxt;
   logic [DATA_BITS-1:0] shift_r, shift_nxt;
   logic                 perr_r, perr_nxt;
   logic                 ferr_r, ferr_nxt;
   logic                 armed_r, armed_nxt;
   logic                 commit_s;
   logic                 mid_s;
   logic [DATA_BITS-1:0] data_out_r;
   logic                 data_ready_r, parity_err_r, frame_err_r, overrun_r, busy_r;

   assign line_s = sync2_r;
   assign tick_s = (div_cnt_r == DIV_W'(TICK_DIV - 1));
   assign mid_s  = (smp_cnt_r == SMP_W'(OVERSAMPLE - 1));

   // Two-flop synchronizer for the asynchronous serial line; resets to idle level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= bit_in;
         sync2_r <= sync1_r;
      end
   end

   // Free-running oversample tick divider.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         div_cnt_r <= '0;
      else if (tick_s) div_cnt_r <= '0;
      else             div_cnt_r <= div_cnt_r + DIV_W'(1);
   end

   // Receive FSM state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         smp_cnt_r <= '0;
         bit_cnt_r <= '0;
         shift_r   <= '0;
         perr_r    <= 1'b0;
         ferr_r    <= 1'b0;
         armed_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         smp_cnt_r <= smp_nxt;
         bit_cnt_r <= bit_nxt;
         shift_r   <= shift_nxt;
         perr_r    <= perr_nxt;
         ferr_r    <= ferr_nxt;
         armed_r   <= armed_nxt;
      end
   end

   // Next-state logic; armed_r blocks a new start until the line has been seen high (break).
   always_comb begin
      state_nxt = state_r;
      smp_nxt   = smp_cnt_r;
      bit_nxt   = bit_cnt_r;
      shift_nxt = shift_r;
      perr_nxt  = perr_r;
      ferr_nxt  = ferr_r;
      armed_nxt = armed_r;
      commit_s  = 1'b0;
      if (tick_s) begin
         case (state_r)
            ST_IDLE: begin
               if (line_s) begin
                  armed_nxt = 1'b1;
               end else if (armed_r) begin
                  state_nxt = ST_START;
                  smp_nxt   = '0;
               end else begin
                  armed_nxt = 1'b0;
               end
            end
            ST_START: begin
               if (smp_cnt_r == SMP_W'(OVERSAMPLE / 2 - 1)) begin
                  smp_nxt = '0;
                  if (line_s) begin
                     state_nxt = ST_IDLE;
                  end else begin
                     state_nxt = ST_DATA;
                     bit_nxt   = '0;
                     perr_nxt  = 1'b0;
                     ferr_nxt  = 1'b0;
                  end
               end else begin
                  smp_nxt = smp_cnt_r + SMP_W'(1);
               end
            end
            ST_DATA: begin
               if (mid_s) begin
                  smp_nxt   = '0;
                  shift_nxt = {line_s, shift_r[DATA_BITS-1:1]};
                  if (bit_cnt_r == BIT_W'(DATA_BITS - 1)) begin
                     bit_nxt   = '0;
                     state_nxt = (PARITY != 32'sd0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_nxt = bit_cnt_r + BIT_W'(1);
                  end
               end else begin
                  smp_nxt = smp_cnt_r + SMP_W'(1);
               end
            end
            ST_PARITY: begin
               if (mid_s) begin
                  smp_nxt   = '0;
                  bit_nxt   = '0;
                  perr_nxt  = parity_error(shift_r, line_s, PAR_MODE);
                  state_nxt = ST_STOP;
               end else begin
                  smp_nxt = smp_cnt_r + SMP_W'(1);
               end
            end
            ST_STOP: begin
               if (mid_s) begin
                  smp_nxt  = '0;
                  ferr_nxt = ferr_r | ~line_s;
                  if (bit_cnt_r == BIT_W'(STOP_BITS - 1)) begin
                     state_nxt = ST_IDLE;
                     commit_s  = 1'b1;
                     armed_nxt = line_s;
                  end else begin
                     bit_nxt = bit_cnt_r + BIT_W'(1);
                  end
               end else begin
                  smp_nxt = smp_cnt_r + SMP_W'(1);
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end else begin
         commit_s = 1'b0;
      end
   end

   // Output buffer: commit, handshake and overrun; an accepted ack frees the slot for a same-cycle commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_r   <= '0;
         data_ready_r <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
         overrun_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         if (commit_s) begin
            if (!data_ready_r || rx.data_ack) begin
               data_out_r   <= shift_r;
               parity_err_r <= perr_r;
               frame_err_r  <= ferr_nxt;
               data_ready_r <= 1'b1;
            end else begin
               overrun_r <= 1'b1;
            end
         end else if (data_ready_r && rx.data_ack) begin
            data_ready_r <= 1'b0;
            overrun_r    <= 1'b0;
         end
         busy_r <= (state_nxt != ST_IDLE);
      end
   end

   assign rx.data_out   = data_out_r;
   assign rx.data_ready = data_ready_r;
   assign rx.parity_err = parity_err_r;
   assign rx.frame_err  = frame_err_r;
   assign rx.overrun    = overrun_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 and an 8E1 instance at 160 clk per bit,
// table-driven frames plus hand-written overrun, glitch, break and reset sequences.
module tb_uart_rx;

   localparam int BIT = 160;

   logic clk;
   logic rst;
   logic line_n, line_e;
   logic busy_n, busy_e;
   int   n_tests;
   int   n_fail;

   uart_rx_if #(.DATA_BITS(8)) if_n ();
   uart_rx_if #(.DATA_BITS(8)) if_e ();

   uart_rx #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
             .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
      .clk(clk), .rst(rst), .bit_in(line_n), .busy(busy_n), .rx(if_n.master));

   uart_rx #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
             .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
      .clk(clk), .rst(rst), .bit_in(line_e), .busy(busy_e), .rx(if_e.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         sel;      // 0: 8N1 instance, 1: 8E1 instance
      logic [7:0] data;
      bit         pbit;
      logic [7:0] exp_data;
      bit         exp_perr;
   } vec_t;

   vec_t vecs[6];

   typedef struct {
      logic [7:0] data;
      logic       rdy;
      logic       perr;
      logic       ferr;
      logic       ovr;
      logic       bsy;
   } stat_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic stat_t rd(input bit sel);
      stat_t s;
      if (sel) begin
         s.data = if_e.data_out; s.rdy = if_e.data_ready; s.perr = if_e.parity_err;
         s.ferr = if_e.frame_err; s.ovr = if_e.overrun; s.bsy = busy_e;
      end else begin
         s.data = if_n.data_out; s.rdy = if_n.data_ready; s.perr = if_n.parity_err;
         s.ferr = if_n.frame_err; s.ovr = if_n.overrun; s.bsy = busy_n;
      end
      return s;
   endfunction

   task automatic drive(input bit sel, input logic v, input int nclk);
      if (sel) line_e = v;
      else     line_n = v;
      repeat (nclk) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                             input bit pbit, input bit stop);
      drive(sel, 1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
      if (has_par) drive(sel, pbit, BIT);
      drive(sel, stop, BIT);
   endtask

   task automatic wait_ready(input bit sel, input string name);
      stat_t s;
      s = rd(sel);
      for (int i = 0; i < 200 && !s.rdy; i++) begin
         @(negedge clk);
         s = rd(sel);
      end
      check(name, 32'(s.rdy), 32'd1);
   endtask

   task automatic do_ack(input bit sel, input string name);
      stat_t s;
      @(negedge clk);
      if (sel) if_e.data_ack = 1'b1;
      else     if_n.data_ack = 1'b1;
      @(posedge clk);
      #1;
      s = rd(sel);
      check(name, 32'(s.rdy), 32'd0);
      @(negedge clk);
      if_e.data_ack = 1'b0;
      if_n.data_ack = 1'b0;
   endtask

   initial begin
      stat_t s;
      bit    busy_seen;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      line_n = 1'b1;
      line_e = 1'b1;
      if_n.data_ack = 1'b0;
      if_e.data_ack = 1'b0;

      vecs[0] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
      vecs[1] = '{1'b1, 8'h03, 1'b1, 8'h03, 1'b1};
      vecs[2] = '{1'b1, 8'h03, 1'b0, 8'h03, 1'b0};
      vecs[3] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
      vecs[4] = '{1'b1, 8'h80, 1'b1, 8'h80, 1'b0};
      vecs[5] = '{1'b1, 8'h7F, 1'b0, 8'h7F, 1'b1};

      repeat (3) @(negedge clk);
      s = rd(1'b0);
      check("rst_data", 32'(s.data), 32'd0);
      check("rst_ready", 32'(s.rdy), 32'd0);
      check("rst_overrun", 32'(s.ovr), 32'd0);
      check("rst_busy", 32'(s.bsy), 32'd0);
      rst = 1'b0;
      drive(1'b0, 1'b1, 2 * BIT);

      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].sel, vecs[v].data, vecs[v].sel, vecs[v].pbit, 1'b1);
         wait_ready(vecs[v].sel, $sformatf("v%0d_ready", v));
         s = rd(vecs[v].sel);
         check($sformatf("v%0d_data", v), 32'(s.data), 32'(vecs[v].exp_data));
         check($sformatf("v%0d_perr", v), 32'(s.perr), 32'(vecs[v].exp_perr));
         check($sformatf("v%0d_ferr", v), 32'(s.ferr), 32'd0);
         check($sformatf("v%0d_overrun", v), 32'(s.ovr), 32'd0);
         check($sformatf("v%0d_busy", v), 32'(s.bsy), 32'd0);
         drive(vecs[v].sel, 1'b1, 50);
         s = rd(vecs[v].sel);
         check($sformatf("v%0d_held", v), 32'(s.rdy), 32'd1);
         do_ack(vecs[v].sel, $sformatf("v%0d_ack_clear", v));
      end

      // Back-to-back frames with no ack: second is dropped
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 40);
      s = rd(1'b0);
      check("ovr_ready", 32'(s.rdy), 32'd1);
      check("ovr_data", 32'(s.data), 32'h55);
      check("ovr_flag", 32'(s.ovr), 32'd1);
      do_ack(1'b0, "ovr_ack_ready");
      s = rd(1'b0);
      check("ovr_cleared", 32'(s.ovr), 32'd0);
      drive(1'b0, 1'b1, BIT);

      // Three-tick low glitch on the idle line
      busy_seen = 1'b0;
      drive(1'b0, 1'b0, 30);
      line_n = 1'b1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (busy_n) busy_seen = 1'b1;
      end
      s = rd(1'b0);
      check("glitch_busy_seen", 32'(busy_seen), 32'd1);
      check("glitch_busy_idle", 32'(s.bsy), 32'd0);
      check("glitch_no_commit", 32'(s.rdy), 32'd0);
      drive(1'b0, 1'b1, BIT);

      // Break: 0x00 with stop bit low, line held low afterwards
      send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_ready(1'b0, "brk_ready");
      s = rd(1'b0);
      check("brk_data", 32'(s.data), 32'h00);
      check("brk_ferr", 32'(s.ferr), 32'd1);
      do_ack(1'b0, "brk_ack_clear");
      drive(1'b0, 1'b0, 3 * BIT);
      s = rd(1'b0);
      check("brk_no_rearm_busy", 32'(s.bsy), 32'd0);
      check("brk_no_rearm_ready", 32'(s.rdy), 32'd0);
      drive(1'b0, 1'b1, BIT);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      wait_ready(1'b0, "post_brk_ready");
      s = rd(1'b0);
      check("post_brk_data", 32'(s.data), 32'h5A);
      check("post_brk_ferr", 32'(s.ferr), 32'd0);

      // Leave 0x5A pending, then reset during bit 4 of the next frame
      drive(1'b0, 1'b1, BIT);
      drive(1'b0, 1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(1'b0, i[0] ? 1'b1 : 1'b0, BIT);
      drive(1'b0, 1'b1, 80);
      s = rd(1'b0);
      check("pre_rst_busy", 32'(s.bsy), 32'd1);
      check("pre_rst_ready", 32'(s.rdy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      s = rd(1'b0);
      check("arst_ready", 32'(s.rdy), 32'd0);
      check("arst_data", 32'(s.data), 32'd0);
      check("arst_busy", 32'(s.bsy), 32'd0);
      check("arst_ferr", 32'(s.ferr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b1, 12 * BIT);
      s = rd(1'b0);
      check("post_rst_no_commit", 32'(s.rdy), 32'd0);
      check("post_rst_busy", 32'(s.bsy), 32'd0);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_ready(1'b0, "post_rst_ready");
      s = rd(1'b0);
      check("post_rst_data", 32'(s.data), 32'h3C);
      check("post_rst_flags", 32'({s.perr, s.ferr, s.ovr}), 32'd0);
      do_ack(1'b0, "post_rst_ack");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
